// File: rtl/dff_pkg.sv
// Shared defaults and width helpers for the elastic register pipeline.
package dff_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_DEPTH = 3;

    // Bits needed to count 0..depth valid stages.
    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_stage.sv
// One elastic pipeline stage: valid+data register that refills whenever it is
// empty or its downstream neighbour is taking its contents.
module dff_stage
    import dff_pkg::*;
#(
    parameter int unsigned          WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             i_up_valid,
    input  logic [WIDTH-1:0] i_up_data,
    input  logic             i_dn_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             w_ready;

    assign w_ready = ~r_valid | i_dn_ready;

    // Data only moves with a valid beat so empty slots keep their last value.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            r_valid <= 1'b0;
            r_data  <= RESET_VAL;
        end else if (w_ready) begin
            r_valid <= i_up_valid;
            if (i_up_valid) begin
                r_data <= i_up_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/dff_pipe.sv
// DEPTH-stage elastic register pipeline with valid/ready handshake, bubble
// collapsing, synchronous flush and a registered occupancy count.
module dff_pipe
    import dff_pkg::*;
#(
    parameter int unsigned      WIDTH     = DEF_WIDTH,
    parameter int unsigned      DEPTH     = DEF_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          in_valid,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          in_ready,
    output logic                          out_valid,
    output logic [WIDTH-1:0]              out_data,
    input  logic                          out_ready,
    output logic [occ_width(DEPTH)-1:0]   occupancy
);

    localparam int unsigned OCC_W = occ_width(DEPTH);

    logic [DEPTH-1:0]            w_valid;
    logic [DEPTH-1:0][WIDTH-1:0] w_data;
    logic [DEPTH-1:0]            w_up_valid;
    logic [DEPTH-1:0][WIDTH-1:0] w_up_data;
    logic [DEPTH-1:0]            w_dn_ready;
    logic                        w_in_xfer;
    logic                        w_out_xfer;
    logic [OCC_W-1:0]            r_occ;

    // Downstream of stage i can take a beat unless every later stage is full
    // and the sink stalls; written flat so the chain has no ripple through bits.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_first
            assign w_up_valid[i] = in_valid;
            assign w_up_data[i]  = in_data;
        end else begin : g_inner
            assign w_up_valid[i] = w_valid[i-1];
            assign w_up_data[i]  = w_data[i-1];
        end

        if (i == DEPTH - 1) begin : g_last
            assign w_dn_ready[i] = out_ready;
        end else begin : g_mid
            assign w_dn_ready[i] = out_ready | ~(&w_valid[DEPTH-1:i+1]);
        end

        dff_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk        (clk),
            .reset      (reset),
            .flush      (flush),
            .i_up_valid (w_up_valid[i]),
            .i_up_data  (w_up_data[i]),
            .i_dn_ready (w_dn_ready[i]),
            .o_valid    (w_valid[i]),
            .o_data     (w_data[i])
        );
    end

    assign in_ready   = out_ready | ~(&w_valid);
    assign out_valid  = w_valid[DEPTH-1];
    assign out_data   = w_data[DEPTH-1];
    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = w_valid[DEPTH-1] & out_ready;

    // Occupancy tracks transfers so it equals the number of valid stages.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            r_occ <= '0;
        end else begin
            r_occ <= r_occ + OCC_W'(w_in_xfer) - OCC_W'(w_out_xfer);
        end
    end

    assign occupancy = r_occ;

endmodule

// File: tb/tb_dff_pipe.sv
// Bench for dff_pipe: three depths against a beat-position reference model,
// directed scenarios on the DEPTH=3 instance, then randomized traffic.
module tb_dff_pipe;

    localparam int N = 3;
    localparam int DEP [N] = '{1, 3, 5};
    localparam logic [7:0] RV [N] = '{8'h3C, 8'hA5, 8'h00};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        flush;
    logic        iv  [N];
    logic [7:0]  id  [N];
    logic        ir  [N];
    logic        ov  [N];
    logic [7:0]  od  [N];
    logic        orr [N];
    logic [0:0]  occ1;
    logic [1:0]  occ3;
    logic [2:0]  occ5;
    logic [31:0] occ_v [N];

    assign occ_v[0] = 32'(occ1);
    assign occ_v[1] = 32'(occ3);
    assign occ_v[2] = 32'(occ5);

    dff_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h3C)) u_d1 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(iv[0]), .in_data(id[0]), .in_ready(ir[0]),
        .out_valid(ov[0]), .out_data(od[0]), .out_ready(orr[0]),
        .occupancy(occ1)
    );

    dff_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'hA5)) u_d3 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(iv[1]), .in_data(id[1]), .in_ready(ir[1]),
        .out_valid(ov[1]), .out_data(od[1]), .out_ready(orr[1]),
        .occupancy(occ3)
    );

    dff_pipe #(.WIDTH(8), .DEPTH(5), .RESET_VAL(8'h00)) u_d5 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(iv[2]), .in_data(id[2]), .in_ready(ir[2]),
        .out_valid(ov[2]), .out_data(od[2]), .out_ready(orr[2]),
        .occupancy(occ5)
    );

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;

    // Reference: ordered beats in flight, each with its current stage index.
    logic [7:0] mq [N][$];
    int         mp [N][$];

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[depth %0d] observed %0h expected %0h", tag, DEP[k], obs, exp);
        end
    endtask

    // Compare DUT to model, then advance the model across one rising edge.
    task automatic step();
        logic ex_ir [N];
        logic ex_ov [N];
        int   prev;
        int   np;
        #1;
        for (int k = 0; k < N; k++) begin
            ex_ir[k] = orr[k] || (mq[k].size() < DEP[k]);
            ex_ov[k] = (mq[k].size() > 0) && (mp[k][0] == DEP[k] - 1);
            if (armed) begin
                chk("in_ready", k, 32'(ir[k]), 32'(ex_ir[k]));
                chk("out_valid", k, 32'(ov[k]), 32'(ex_ov[k]));
                chk("occupancy", k, occ_v[k], 32'(mq[k].size()));
                if (ex_ov[k]) chk("out_data", k, 32'(od[k]), 32'(mq[k][0]));
            end
        end
        @(posedge clk);
        if (!reset || flush) begin
            for (int k = 0; k < N; k++) begin
                mq[k].delete();
                mp[k].delete();
            end
            if (!reset) armed = 1'b1;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (ex_ov[k] && orr[k]) begin
                    void'(mq[k].pop_front());
                    void'(mp[k].pop_front());
                end
                // A beat advances one stage per cycle unless the beat ahead blocks it.
                prev = DEP[k];
                for (int j = 0; j < mp[k].size(); j++) begin
                    np = mp[k][j] + 1;
                    if (np > prev - 1) np = prev - 1;
                    mp[k][j] = np;
                    prev = np;
                end
                if (iv[k] && ex_ir[k]) begin
                    mq[k].push_back(id[k]);
                    mp[k].push_back(0);
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] bp [3];
        reset = 1'b0;
        flush = 1'b0;
        for (int k = 0; k < N; k++) begin
            iv[k]  = 1'b0;
            id[k]  = 8'h00;
            orr[k] = 1'b1;
        end
        @(negedge clk);
        step();
        step();

        // Reset state
        reset = 1'b1;
        #1;
        chk("rst_out_valid", 1, 32'(ov[1]), 32'd0);
        chk("rst_occupancy", 1, occ_v[1], 32'd0);
        chk("rst_in_ready", 1, 32'(ir[1]), 32'd1);
        for (int k = 0; k < N; k++) chk("rst_out_data", k, 32'(od[k]), 32'(RV[k]));
        step();

        // Back-to-back streaming
        for (int i = 0; i < 16; i++) begin
            iv[1] = 1'b1;
            id[1] = 8'(i + 1);
            #1;
            if (i == 2) chk("lat_not_yet", 1, 32'(ov[1]), 32'd0);
            if (i == 3) begin
                chk("lat_valid", 1, 32'(ov[1]), 32'd1);
                chk("lat_data", 1, 32'(od[1]), 32'h01);
            end
            if (i == 8) begin
                chk("stream_occ", 1, occ_v[1], 32'd3);
                chk("stream_ready", 1, 32'(ir[1]), 32'd1);
            end
            step();
        end
        iv[1] = 1'b0;
        repeat (4) step();

        // Backpressure fill
        orr[1] = 1'b0;
        bp = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 3; i++) begin
            iv[1] = 1'b1;
            id[1] = bp[i];
            step();
        end
        id[1] = 8'h44;
        #1;
        chk("bp_full_ready", 1, 32'(ir[1]), 32'd0);
        chk("bp_full_occ", 1, occ_v[1], 32'd3);
        step();
        orr[1] = 1'b1;
        #1;
        chk("bp_pass_ready", 1, 32'(ir[1]), 32'd1);
        chk("bp_head", 1, 32'(od[1]), 32'h11);
        step();
        iv[1] = 1'b0;
        bp = '{8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_drain_valid", 1, 32'(ov[1]), 32'd1);
            chk("bp_drain_data", 1, 32'(od[1]), 32'(bp[i]));
            step();
        end
        step();

        // Bubble collapse
        orr[1] = 1'b0;
        iv[1] = 1'b1; id[1] = 8'h55; step();
        iv[1] = 1'b0; step(); step();
        iv[1] = 1'b1; id[1] = 8'h66; step();
        iv[1] = 1'b0;
        #1;
        chk("bubble_occ", 1, occ_v[1], 32'd2);
        chk("bubble_valid", 1, 32'(ov[1]), 32'd1);
        chk("bubble_data", 1, 32'(od[1]), 32'h55);
        step();

        // Flush mid-stream discards the concurrent input beat
        iv[1] = 1'b1; id[1] = 8'h88; step();
        flush = 1'b1; id[1] = 8'h77; orr[1] = 1'b1;
        #1;
        chk("flush_pre_occ", 1, occ_v[1], 32'd3);
        chk("flush_ready", 1, 32'(ir[1]), 32'd1);
        step();
        flush = 1'b0; iv[1] = 1'b0;
        #1;
        chk("flush_occ", 1, occ_v[1], 32'd0);
        chk("flush_valid", 1, 32'(ov[1]), 32'd0);
        chk("flush_data", 1, 32'(od[1]), 32'hA5);
        repeat (5) step();

        // Reset while flushing a full pipe
        orr[1] = 1'b0;
        bp = '{8'hAA, 8'hBB, 8'hCC};
        for (int i = 0; i < 3; i++) begin
            iv[1] = 1'b1;
            id[1] = bp[i];
            step();
        end
        id[1] = 8'hDD; flush = 1'b1; reset = 1'b0;
        step();
        reset = 1'b1; flush = 1'b0; iv[1] = 1'b0; orr[1] = 1'b1;
        #1;
        chk("rstfl_valid", 1, 32'(ov[1]), 32'd0);
        chk("rstfl_data", 1, 32'(od[1]), 32'hA5);
        chk("rstfl_occ", 1, occ_v[1], 32'd0);
        chk("rstfl_ready", 1, 32'(ir[1]), 32'd1);
        step();

        // Randomized traffic on all depths
        for (int c = 0; c < 10000; c++) begin
            for (int k = 0; k < N; k++) begin
                iv[k]  = ($urandom_range(0, 3) != 0);
                id[k]  = 8'($urandom);
                orr[k] = ($urandom_range(0, 4) >= 2);
            end
            flush = ($urandom_range(0, 499) == 0);
            reset = ($urandom_range(0, 1999) != 0);
            step();
        end
        flush = 1'b0;
        reset = 1'b1;
        for (int k = 0; k < N; k++) begin
            iv[k]  = 1'b0;
            orr[k] = 1'b1;
        end
        repeat (8) step();
        #1;
        for (int k = 0; k < N; k++) chk("drained_occ", k, occ_v[k], 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dff_pipe.md
Name: dff_pipe

Overview:
- Parametrised successor to the single-bit D flip-flop: a DEPTH-stage, WIDTH-bit elastic register pipeline with valid/ready handshake, per-stage bubble collapsing, synchronous flush and occupancy count.
- Used wherever a datapath needs fixed-latency retiming that still tolerates downstream backpressure without dropping or duplicating data.

Parameters:
- WIDTH, 8, data bits per stage (>=1).
- DEPTH, 3, number of register stages (>=1).
- RESET_VAL, '0, WIDTH-bit value loaded into every data register on reset and flush.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
- flush  input  1  synchronous clear of all stages; active high.
- in_valid  input  1  upstream data valid.
- in_data  input  WIDTH  upstream data.
- in_ready  output  1  pipeline can accept in_data this cycle.
- out_valid  output  1  last stage holds valid data.
- out_data  output  WIDTH  last-stage data.
- out_ready  input  1  downstream accepts out_data this cycle.
- occupancy  output  $clog2(DEPTH+1)  number of valid stages (0..DEPTH).

Behaviour:
- Stage i (0..DEPTH-1) holds v[i] and d[i]. Stage 0 is the input side; stage DEPTH-1 drives out_valid and out_data.
- Ready chain (combinational): rdy[DEPTH-1] = !v[DEPTH-1] | out_ready; rdy[i] = !v[i] | rdy[i+1]; in_ready = rdy[0].
- Stage update on rising clk when rdy[i]=1:
  - v[i] <= v[i-1]; d[i] <= d[i-1] if v[i-1]=1, else d[i] holds.
  - Stage 0 takes in_valid and in_data.
- When rdy[i]=0 the stage holds v and d unchanged.
- Transfer rules: an input transfer occurs when in_valid & in_ready; an output transfer occurs when out_valid & out_ready. There is no loss, duplication or reordering.
- Latency: a beat accepted at edge N appears on out_valid after edge N+DEPTH-1 (visible in cycle N+DEPTH-1), provided no stall. Throughput is 1 beat/cycle with out_ready held at 1.
- Bubbles collapse: an empty stage accepts from upstream even while downstream stalls. Holding out_ready=0 from an empty pipe therefore fills all DEPTH stages; in_ready then drops to 0.
- Full with out_ready=1: in_ready=1 in the same cycle (pass-through ready, no lost cycle).
- occupancy = popcount(v), registered-consistent (derived from v, or a counter updated +1/-1/0 on in/out transfers; the two must match).
- Reset (reset=0 at edge):
  - all v <= 0, all d <= RESET_VAL.
  - out_valid=0, out_data=RESET_VAL, occupancy=0, in_ready=1 from the next cycle.
  - Takes priority over flush and in_valid, including mid-stream; in-flight data is discarded.
- flush=1 at edge (reset=1): same clearing as reset. in_valid that cycle is discarded even if in_ready=1. in_ready itself is not gated by flush.
- out_data is X-free at all times after the first reset.
- Outputs are stable within a cycle and have no combinational path from in_valid/in_data to outputs. The only combinational path is out_ready -> in_ready.

Decomposition:
- Package dff_pkg: function occ_width(depth) = $clog2(depth+1); localparam default WIDTH/DEPTH values.
- One sub-module, dff_stage: a single valid+data register with the rdy logic, parametrised by WIDTH and RESET_VAL, and inputs clk, reset, flush. dff_pipe instantiates DEPTH of them in a generate loop and adds occupancy.

Test Plan:
- Reset: WIDTH=8, DEPTH=3, RESET_VAL=8'hA5, reset=0 for 2 cycles, then 1 -> out_valid=0, out_data=8'hA5, occupancy=0, in_ready=1.
- Streaming: out_ready=1, push 0x01..0x10 back-to-back -> 0x01 appears 2 cycles after acceptance (DEPTH-1), then one beat/cycle in order. occupancy holds 3 in steady state; in_ready stays 1.
- Backpressure fill: out_ready=0, push 0x11,0x22,0x33,0x44 -> first three accepted, in_ready=0 while 0x44 is held, occupancy=3. Raise out_ready -> 0x11,0x22,0x33,0x44 out in order, 0x44 accepted the same cycle out_ready rises.
- Bubble collapse: push 0x55, idle 2 cycles, push 0x66 with out_ready=0 -> both compact to the output end, occupancy=2, out_data=0x55.
- Flush mid-stream: occupancy=3, flush=1 with in_valid=1, in_data=0x77 -> next cycle occupancy=0, out_valid=0, out_data=RESET_VAL, and 0x77 never emerges.
- Reset vs flush priority: reset=0 and flush=1 with pipe full -> identical clear. After release, a random valid/ready scoreboard runs 10k cycles with DEPTH=1 and DEPTH=5, with no loss, duplication or reordering, and occupancy equal to the accepted-minus-delivered count.
